// File: rtl/pipeline_pkg.sv
// Shared pipeline definitions: next-PC select codes, bubble instruction,
// fetch FSM states and the IF/ID register layout.
package pipeline_pkg;

  typedef enum logic [1:0] {
    PCSRC_PLUS4  = 2'b00,
    PCSRC_TARGET = 2'b01,
    PCSRC_ALU    = 2'b10
  } pcsrc_e;

  localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

  typedef enum logic {
    FETCH = 1'b0,
    HOLD  = 1'b1
  } fetch_state_e;

  typedef struct packed {
    logic [31:0] instr;
    logic [31:0] pc;
    logic [31:0] pc_plus4;
    logic        valid;
  } ifid_t;

  // Code 11 is reserved and behaves like PC+4, so it never redirects.
  function automatic logic is_redirect(input logic [1:0] src);
    return (src == PCSRC_TARGET) || (src == PCSRC_ALU);
  endfunction

endpackage

// File: rtl/fetch_stage_if.sv
// Instruction-memory request/ready bus between the fetch stage and imem.
// Handshake: a word transfers in any cycle where imem_req && imem_ready; req may drop or addr change while ready is low.
interface fetch_stage_if;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic [31:0] imem_rdata;
  logic        imem_ready;

  modport master (output imem_req, imem_addr, input imem_rdata, imem_ready);
  modport slave  (input imem_req, imem_addr, output imem_rdata, imem_ready);
endinterface

// File: rtl/flopenr_clr.sv
// Enabled register with synchronous clear; clear wins over enable and
// loads the same value as asynchronous reset.
module flopenr_clr #(
  parameter int           W       = 8,
  parameter logic [W-1:0] CLR_VAL = '0
) (
  input  logic         clk,
  input  logic         n_rst,
  input  logic         en,
  input  logic         clr,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst)   q <= CLR_VAL;
    else if (clr) q <= CLR_VAL;
    else if (en)  q <= d;
  end

endmodule

// File: rtl/pc_next_mux.sv
// Combinational next-PC select: branch target, JALR target (bit 0 cleared),
// or PC+4 / hold for the sequential and reserved codes.
module pc_next_mux
  import pipeline_pkg::*;
(
  input  logic [31:0] pc,
  input  logic [1:0]  pc_src,
  input  logic        advance,
  input  logic [31:0] pc_target,
  input  logic [31:0] alu_result,
  output logic [31:0] pc_next
);

  always_comb begin
    pc_next = pc;
    case (pc_src)
      PCSRC_TARGET: pc_next = pc_target;
      PCSRC_ALU:    pc_next = alu_result & 32'hFFFF_FFFE;
      default:      if (advance) pc_next = pc + 32'd4;
    endcase
  end

endmodule

// File: rtl/fetch_stage.sv
// Instruction-fetch stage: owns PC_F, runs the imem request/ready handshake,
// parks a word fetched during StallF, and drives the IF/ID register.
module fetch_stage
  import pipeline_pkg::*;
#(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter logic [31:0] NOP_INSTR = pipeline_pkg::NOP_INSTR
) (
  input  logic                 clk,
  input  logic                 n_rst,
  input  logic                 StallF,
  input  logic                 StallD,
  input  logic                 FlushD,
  input  logic [1:0]           PCSrc,
  input  logic [31:0]          PCTarget_E,
  input  logic [31:0]          ALUResult_E,
  fetch_stage_if.master        imem,
  output logic                 fetch_busy,
  output logic [31:0]          instr_D,
  output logic [31:0]          PC_D,
  output logic [31:0]          PCPlus4_D,
  output logic                 valid_D,
  output fetch_state_e         fetch_state
);

  localparam ifid_t BUBBLE = '{instr: NOP_INSTR, pc: 32'd0, pc_plus4: 32'd0, valid: 1'b0};

  fetch_state_e state_q, state_d;
  logic [31:0]  pc_q, pc_next, hold_q, deliver_instr;
  logic         redirect, deliver, capture;
  ifid_t        ifid_d, ifid_q;

  // A redirect squashes both a word arriving now and a parked one.
  assign redirect      = is_redirect(PCSrc);
  assign deliver       = !redirect && !StallF &&
                         ((state_q == FETCH && imem.imem_ready) || state_q == HOLD);
  assign capture       = (state_q == FETCH) && imem.imem_ready && StallF && !redirect;
  assign deliver_instr = (state_q == HOLD) ? hold_q : imem.imem_rdata;

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) state_q <= FETCH;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    if (redirect) begin
      state_d = FETCH;
    end else begin
      case (state_q)
        FETCH:   if (imem.imem_ready && StallF) state_d = HOLD;
        HOLD:    if (!StallF) state_d = FETCH;
        default: state_d = FETCH;
      endcase
    end
  end

  always_comb begin
    imem.imem_req = (state_q == FETCH);
    fetch_busy    = (state_q == FETCH) && !imem.imem_ready;
  end

  assign imem.imem_addr = pc_q;
  assign fetch_state    = state_q;

  pc_next_mux u_pc_next_mux (
    .pc         (pc_q),
    .pc_src     (PCSrc),
    .advance    (deliver),
    .pc_target  (PCTarget_E),
    .alu_result (ALUResult_E),
    .pc_next    (pc_next)
  );

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      pc_q   <= RESET_PC;
      hold_q <= 32'd0;
    end else begin
      pc_q <= pc_next;
      if (capture) hold_q <= imem.imem_rdata;
    end
  end

  always_comb begin
    ifid_d          = BUBBLE;
    ifid_d.instr    = deliver_instr;
    ifid_d.pc       = pc_q;
    ifid_d.pc_plus4 = pc_q + 32'd4;
    ifid_d.valid    = 1'b1;
  end

  // Clear covers both FlushD and a cycle with nothing to deliver.
  flopenr_clr #(
    .W       ($bits(ifid_t)),
    .CLR_VAL (BUBBLE)
  ) u_ifid (
    .clk   (clk),
    .n_rst (n_rst),
    .en    (!StallD),
    .clr   (FlushD || (!StallD && !deliver)),
    .d     (ifid_d),
    .q     (ifid_q)
  );

  assign instr_D   = ifid_q.instr;
  assign PC_D      = ifid_q.pc;
  assign PCPlus4_D = ifid_q.pc_plus4;
  assign valid_D   = ifid_q.valid;

endmodule

// File: tb/tb_fetch_stage.sv
// Bench for fetch_stage: directed scenarios then random hazards/imem waits,
// IF/ID checked by a queue-based scoreboard against a transaction-level model.
module tb_fetch_stage;
  import pipeline_pkg::*;

  localparam logic [31:0] RST_PC = 32'h0000_0080;
  localparam logic [96:0] BUBBLE = {NOP_INSTR, 64'd0, 1'b0};

  logic         clk = 1'b0;
  logic         n_rst;
  logic         StallF, StallD, FlushD;
  logic [1:0]   PCSrc;
  logic [31:0]  PCTarget_E, ALUResult_E;
  logic         ready_r;
  logic         fetch_busy;
  logic [31:0]  instr_D, PC_D, PCPlus4_D;
  logic         valid_D;
  fetch_state_e fetch_state;

  int checks = 0;
  int errors = 0;

  logic [96:0] exp_q[$];

  logic [31:0] m_pc;
  logic        m_held;
  logic [31:0] m_word;
  logic [96:0] m_ifid;

  always #5 clk = ~clk;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'h1234_5677;
  endfunction

  fetch_stage_if bus();
  assign bus.imem_ready = ready_r;
  assign bus.imem_rdata = ready_r ? mem_word(bus.imem_addr) : 32'hDEAD_BEEF;

  fetch_stage #(.RESET_PC(RST_PC)) dut (
    .clk         (clk),
    .n_rst       (n_rst),
    .StallF      (StallF),
    .StallD      (StallD),
    .FlushD      (FlushD),
    .PCSrc       (PCSrc),
    .PCTarget_E  (PCTarget_E),
    .ALUResult_E (ALUResult_E),
    .imem        (bus.master),
    .fetch_busy  (fetch_busy),
    .instr_D     (instr_D),
    .PC_D        (PC_D),
    .PCPlus4_D   (PCPlus4_D),
    .valid_D     (valid_D),
    .fetch_state (fetch_state)
  );

  task automatic chk(input string name, input logic [96:0] act, input logic [96:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_pc   = RST_PC;
    m_held = 1'b0;
    m_word = 32'd0;
    m_ifid = BUBBLE;
    exp_q.delete();
  endtask

  // One cycle: drive inputs, check combinational outputs, predict IF/ID.
  task automatic step(input logic stf, input logic std, input logic fld,
                      input logic [1:0] src, input logic [31:0] tgt,
                      input logic [31:0] alu, input logic rdy);
    logic        redirect, avail, deliver;
    logic [31:0] word;
    @(negedge clk);
    StallF = stf; StallD = std; FlushD = fld; PCSrc = src;
    PCTarget_E = tgt; ALUResult_E = alu; ready_r = rdy;
    #1;
    chk("imem_addr", bus.imem_addr, m_pc);
    chk("imem_req", bus.imem_req, !m_held);
    chk("fetch_busy", fetch_busy, !m_held && !rdy);
    chk("fetch_state", fetch_state, m_held ? HOLD : FETCH);
    redirect = (src == 2'b01) || (src == 2'b10);
    avail    = m_held || rdy;
    word     = m_held ? m_word : mem_word(m_pc);
    deliver  = avail && !stf && !redirect;
    if (fld)       m_ifid = BUBBLE;
    else if (!std) m_ifid = deliver ? {word, m_pc, m_pc + 32'd4, 1'b1} : BUBBLE;
    exp_q.push_back(m_ifid);
    if (redirect) begin
      m_pc   = (src == 2'b01) ? tgt : {alu[31:1], 1'b0};
      m_held = 1'b0;
    end else if (deliver) begin
      m_pc   = m_pc + 32'd4;
      m_held = 1'b0;
    end else if (rdy && !m_held && stf) begin
      m_held = 1'b1;
      m_word = word;
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_instr_D"}, instr_D, NOP_INSTR);
    chk({tag, "_valid_D"}, valid_D, 1'b0);
    chk({tag, "_PC_D"}, PC_D, 32'd0);
    chk({tag, "_PCPlus4_D"}, PCPlus4_D, 32'd0);
    chk({tag, "_imem_addr"}, bus.imem_addr, RST_PC);
    chk({tag, "_state"}, fetch_state, FETCH);
  endtask

  // Monitor: IF/ID is compared just after every active edge.
  initial begin
    logic [96:0] exp;
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() > 0) begin
        exp = exp_q.pop_front();
        chk("ifid", {instr_D, PC_D, PCPlus4_D, valid_D}, exp);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    n_rst = 1'b0;
    StallF = 0; StallD = 0; FlushD = 0; PCSrc = 2'b00;
    PCTarget_E = 0; ALUResult_E = 0; ready_r = 0;
    model_reset();
    #12;
    check_reset_outputs("reset");
    @(negedge clk);
    n_rst = 1'b1;

    // Sequential fetch, then redirect to 0 for 0/4/8 with a 3-cycle wait at 8.
    step(0, 0, 0, 2'b00, 0, 0, 1);
    step(0, 0, 1, 2'b01, 32'h0, 0, 1);
    step(0, 0, 0, 2'b00, 0, 0, 1);
    step(0, 0, 0, 2'b00, 0, 0, 1);
    repeat (3) step(0, 0, 0, 2'b00, 0, 0, 0);
    step(0, 0, 0, 2'b00, 0, 0, 1);

    // Word parked during stall, released with imem not ready.
    step(1, 1, 0, 2'b00, 0, 0, 1);
    step(1, 1, 0, 2'b00, 0, 0, 1);
    step(0, 0, 0, 2'b00, 0, 0, 0);
    step(0, 0, 0, 2'b00, 0, 0, 1);

    // Redirects during a stall and via JALR with odd target.
    step(1, 1, 0, 2'b00, 0, 0, 1);
    step(1, 1, 1, 2'b01, 32'h100, 0, 1);
    step(0, 0, 0, 2'b00, 0, 0, 1);
    step(0, 0, 1, 2'b10, 0, 32'h203, 1);
    step(0, 0, 0, 2'b00, 0, 0, 1);

    // Flush over stall, reserved PCSrc, and PC wrap.
    step(0, 1, 1, 2'b00, 0, 0, 1);
    step(0, 0, 0, 2'b11, 32'h500, 32'h600, 1);
    step(0, 0, 0, 2'b00, 0, 0, 1);
    step(0, 0, 1, 2'b01, 32'hFFFF_FFFC, 0, 1);
    step(0, 0, 0, 2'b00, 0, 0, 1);
    step(0, 0, 0, 2'b00, 0, 0, 1);

    // Asynchronous reset during a wait at 0x40.
    step(0, 0, 1, 2'b01, 32'h40, 0, 1);
    step(0, 0, 0, 2'b00, 0, 0, 0);
    step(0, 0, 0, 2'b00, 0, 0, 0);
    #3;
    n_rst = 1'b0;
    model_reset();
    #1;
    check_reset_outputs("async_reset");
    repeat (2) @(negedge clk);
    n_rst = 1'b1;
    step(0, 0, 0, 2'b00, 0, 0, 1);
    step(0, 0, 0, 2'b00, 0, 0, 1);

    // Random hazards, redirects and imem waits.
    for (int i = 0; i < 600; i++) begin
      logic       stf, std, fld, rdy;
      logic [1:0] src;
      int         r;
      stf = ($urandom_range(0, 3) == 0);
      std = ($urandom_range(0, 4) == 0);
      fld = ($urandom_range(0, 9) == 0);
      rdy = ($urandom_range(0, 9) < 7);
      r   = $urandom_range(0, 19);
      src = (r == 0) ? 2'b01 : (r == 1) ? 2'b10 : (r == 2) ? 2'b11 : 2'b00;
      step(stf, std, fld, src, $urandom() & 32'hFFFF_FFFC, $urandom(), rdy);
    end

    step(0, 0, 0, 2'b00, 0, 0, 0);
    @(posedge clk);
    #2;
    chk("drain", exp_q.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
